// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED sequencer
// Purpose: state and sweep-mode enumerations plus the position width used by
//          led_seq_driver and its helpers. No ports.
package led_seq_pkg;

    localparam int POS_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_PING = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

endpackage

// File: rtl/led_seq_driver_tick_gen.sv
// rtl/led_seq_driver_tick_gen.sv - prescaler producing one tick every DIV enabled cycles
// Purpose: counts 0..DIV-1 while en is high and is held at 0 otherwise, so the
//          first tick after en rises lands exactly DIV edges after the rise.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   en   in  count enable (high only while the sequencer is running)
//   tick out combinational pulse, high in the last cycle of each period
module tick_gen #(
    parameter int DIV   = 12_500_000,
    parameter int DIV_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == DIV_W'(DIV - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_driver.sv
// rtl/led_seq_driver.sv - run/pause sequencer driving the LED decoder and 1-to-8 demux
// Purpose: prescaled 4-bit position counter with up/down/ping-pong/hold sweeps,
//          controlled by an IDLE/RUN/PAUSE FSM. All outputs come from registers.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       IDLE/PAUSE -> RUN
//   stop        RUN -> PAUSE (beats start when both are high)
//   clear       any state -> IDLE, position/phase/direction cleared
//   step        one advance per high cycle, PAUSE only
//   mode[1:0]   00 up, 01 down, 10 ping-pong, 11 hold
//   led_ctrl    current position
//   demux_ctrl  position[2:0]
//   demux_en    high in RUN or PAUSE
//   demux_in    phase bit, toggles on every wrap
//   wrap        one-cycle pulse registered with the wrapping position
//   active      high only in RUN
module led_seq_driver
    import led_seq_pkg::*;
#(
    parameter int DIV   = 12_500_000,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             step,
    input  logic [1:0]       mode,
    output logic [POS_W-1:0] led_ctrl,
    output logic [2:0]       demux_ctrl,
    output logic             demux_en,
    output logic             demux_in,
    output logic             wrap,
    output logic             active
);

    localparam logic [POS_W-1:0] POS_MAX = '1;

    state_t           r_state, w_state_next;
    logic [POS_W-1:0] r_pos, w_pos_next;
    logic             r_dir_down, w_dir_down_next;
    logic             r_phase, w_phase_next;
    logic             r_wrap, w_wrap_next;
    logic             r_demux_en, r_active;
    logic             w_tick, w_advance;
    mode_t            w_mode;

    assign w_mode = mode_t'(mode);

    tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == RUN),
        .tick (w_tick)
    );

    // Next state and advance request. A tick on the cycle that leaves RUN is
    // dropped so a stop always freezes the position it sees.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!stop && start) w_state_next = RUN;
                end
                RUN: begin
                    if (stop) w_state_next = PAUSE;
                    else      w_advance    = w_tick;
                end
                PAUSE: begin
                    if (stop)       w_state_next = PAUSE;
                    else if (start) w_state_next = RUN;
                    else if (step)  w_advance    = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Position, direction and wrap update.
    always_comb begin
        w_pos_next      = r_pos;
        w_dir_down_next = r_dir_down;
        w_wrap_next     = 1'b0;
        if (clear) begin
            w_pos_next      = '0;
            w_dir_down_next = 1'b0;
        end else if (w_advance) begin
            unique case (w_mode)
                MODE_UP: begin
                    w_pos_next  = r_pos + 1'b1;
                    w_wrap_next = (r_pos == POS_MAX);
                end
                MODE_DOWN: begin
                    w_pos_next  = r_pos - 1'b1;
                    w_wrap_next = (r_pos == '0);
                end
                MODE_PING: begin
                    // Endpoints bounce immediately so 15 and 0 are each shown once.
                    if (!r_dir_down) begin
                        if (r_pos == POS_MAX) begin
                            w_pos_next      = POS_MAX - 1'b1;
                            w_dir_down_next = 1'b1;
                        end else begin
                            w_pos_next = r_pos + 1'b1;
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_pos_next      = POS_W'(1);
                            w_dir_down_next = 1'b0;
                        end else begin
                            w_pos_next  = r_pos - 1'b1;
                            w_wrap_next = (r_pos == POS_W'(1));
                        end
                    end
                end
                MODE_HOLD: begin
                    w_pos_next = r_pos;
                end
                default: w_pos_next = r_pos;
            endcase
        end
        w_phase_next = clear ? 1'b0 : (r_phase ^ w_wrap_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pos      <= '0;
            r_dir_down <= 1'b0;
            r_phase    <= 1'b0;
            r_wrap     <= 1'b0;
            r_demux_en <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pos      <= w_pos_next;
            r_dir_down <= w_dir_down_next;
            r_phase    <= w_phase_next;
            r_wrap     <= w_wrap_next;
            r_demux_en <= (w_state_next != IDLE);
            r_active   <= (w_state_next == RUN);
        end
    end

    assign led_ctrl   = r_pos;
    assign demux_ctrl = r_pos[2:0];
    assign demux_en   = r_demux_en;
    assign demux_in   = r_phase;
    assign wrap       = r_wrap;
    assign active     = r_active;

endmodule

// File: tb/tb_led_seq_driver.sv
// tb/tb_led_seq_driver.sv - self-checking bench for led_seq_driver against a behavioural model
module tb_led_seq_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, clear, step;
    logic [1:0] mode;
    logic [3:0] led_ctrl;
    logic [2:0] demux_ctrl;
    logic       demux_en, demux_in, wrap, active;

    led_seq_driver #(.DIV(DIV), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .step       (step),
        .mode       (mode),
        .led_ctrl   (led_ctrl),
        .demux_ctrl (demux_ctrl),
        .demux_en   (demux_en),
        .demux_in   (demux_in),
        .wrap       (wrap),
        .active     (active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 idle, 1 run, 2 pause. m_age counts edges spent in RUN.
    int m_state = 0;
    int m_pos   = 0;
    int m_phase = 0;
    int m_wrap  = 0;
    int m_age   = 0;
    bit m_up    = 1'b1;

    task automatic model_edge();
        int k;
        bit adv;
        adv    = 1'b0;
        m_wrap = 0;
        if (rst || clear) begin
            m_state = 0; m_pos = 0; m_up = 1'b1; m_phase = 0; m_age = 0;
            return;
        end
        case (m_state)
            0: if (!stop && start) begin m_state = 1; m_age = 0; end
            1: if (stop) m_state = 2;
               else begin m_age++; adv = ((m_age % DIV) == 0); end
            default: if (!stop) begin
                   if (start) begin m_state = 1; m_age = 0; end
                   else if (step) adv = 1'b1;
               end
        endcase
        if (adv) begin
            case (mode)
                2'd0: begin m_pos = (m_pos + 1) % 16;  m_wrap = (m_pos == 0);  end
                2'd1: begin m_pos = (m_pos + 15) % 16; m_wrap = (m_pos == 15); end
                2'd2: begin
                    // ping-pong as a 30-step cycle: k 0..15 rising, 16..29 falling
                    k = m_up ? m_pos : (30 - m_pos) % 30;
                    k = (k + 1) % 30;
                    m_pos  = (k <= 15) ? k : 30 - k;
                    m_up   = (k >= 1 && k <= 15);
                    m_wrap = (k == 0);
                end
                default: ;
            endcase
        end
        if (m_wrap != 0) m_phase = 1 - m_phase;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        n_vec++;
        chk({tag, ".led_ctrl"},   32'(led_ctrl),   32'(m_pos));
        chk({tag, ".demux_ctrl"}, 32'(demux_ctrl), 32'(m_pos % 8));
        chk({tag, ".demux_en"},   32'(demux_en),   32'(m_state != 0));
        chk({tag, ".demux_in"},   32'(demux_in),   32'(m_phase));
        chk({tag, ".wrap"},       32'(wrap),       32'(m_wrap));
        chk({tag, ".active"},     32'(active),     32'(m_state == 1));
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) cycle(tag);
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit c,
                         input bit t, input logic [1:0] m);
        rst = r; start = s; stop = p; clear = c; step = t; mode = m;
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 2'd0);
        // Reset with start held high
        run(2, "reset");
        chk("reset_led", 32'(led_ctrl), 0);
        chk("reset_en", 32'(demux_en), 0);
        drive(0, 0, 0, 0, 0, 2'd0);
        run(3, "idle");

        // Up sweep
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "up_start");
        drive(0, 0, 0, 0, 0, 2'd0); run(3, "up_lat");
        chk("up_lat_hold", 32'(led_ctrl), 0);
        run(1, "up_first");
        chk("up_first", 32'(led_ctrl), 1);
        run(60, "up_sweep");
        chk("up_wrap_pos", 32'(led_ctrl), 0);
        chk("up_wrap_pulse", 32'(wrap), 1);
        chk("up_phase", 32'(demux_in), 1);
        run(1, "up_after");
        chk("up_wrap_once", 32'(wrap), 0);

        // Down sweep from reset
        drive(1, 0, 0, 0, 0, 2'd1); run(1, "down_rst");
        drive(0, 1, 0, 0, 0, 2'd1); run(1, "down_start");
        drive(0, 0, 0, 0, 0, 2'd1); run(4, "down_first");
        chk("down_first", 32'(led_ctrl), 15);
        chk("down_wrap", 32'(wrap), 1);
        run(4, "down_second");
        chk("down_second", 32'(led_ctrl), 14);

        // Ping-pong full cycle, then hold and resume
        drive(1, 0, 0, 0, 0, 2'd2); run(1, "ping_rst");
        drive(0, 1, 0, 0, 0, 2'd2); run(1, "ping_start");
        drive(0, 0, 0, 0, 0, 2'd2); run(4 * 30, "ping_cycle");
        chk("ping_back_to_0", 32'(led_ctrl), 0);
        run(4 * 20, "ping_mid");
        drive(0, 0, 0, 0, 0, 2'd3); run(16, "ping_hold");
        drive(0, 0, 0, 0, 0, 2'd2); run(24, "ping_resume");

        // Pause and step
        drive(1, 0, 0, 0, 0, 2'd0); run(1, "pause_rst");
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "pause_start");
        drive(0, 0, 0, 0, 0, 2'd0); run(20, "pause_run");
        drive(0, 0, 1, 0, 0, 2'd0); run(1, "pause_stop");
        drive(0, 0, 0, 0, 0, 2'd0); run(20, "pause_hold");
        chk("pause_pos", 32'(led_ctrl), 5);
        chk("pause_active", 32'(active), 0);
        chk("pause_en", 32'(demux_en), 1);
        drive(0, 0, 0, 0, 1, 2'd0); run(2, "pause_step");
        chk("step_pos", 32'(led_ctrl), 7);
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "resume_start");
        drive(0, 0, 0, 0, 0, 2'd0); run(4, "resume_lat");
        chk("resume_pos", 32'(led_ctrl), 8);
        drive(0, 1, 1, 0, 0, 2'd0); run(1, "start_stop");
        chk("start_stop_active", 32'(active), 0);
        drive(0, 0, 0, 0, 0, 2'd0); run(4, "start_stop_hold");

        // Clear and reset mid-run
        drive(1, 0, 0, 0, 0, 2'd0); run(1, "clr_rst");
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "clr_start");
        drive(0, 0, 0, 0, 0, 2'd0); run(36, "clr_run");
        chk("clr_at_9", 32'(led_ctrl), 9);
        drive(0, 0, 0, 1, 0, 2'd0); run(1, "clear");
        chk("clear_pos", 32'(led_ctrl), 0);
        chk("clear_en", 32'(demux_en), 0);
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "clr_restart");
        drive(0, 0, 0, 0, 0, 2'd0); run(36, "rst_run");
        drive(1, 0, 0, 0, 0, 2'd0); run(1, "midrun_rst");
        chk("rst_pos", 32'(led_ctrl), 0);
        chk("rst_en", 32'(demux_en), 0);
        drive(0, 1, 0, 0, 0, 2'd0); run(1, "rst_restart");
        drive(0, 0, 0, 0, 0, 2'd0); run(4, "rst_lat");
        chk("rst_restart_pos", 32'(led_ctrl), 1);

        // Randomized control traffic
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 99) < 8);
            stop  = ($urandom_range(0, 99) < 6);
            step  = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
